// File: rtl/b_cpu_pkg.sv
// Shared definitions for the B-processor: opcodes, ALU function codes,
// instruction field layout and transmit-line symbols.
// CPU_MUL_EN: when defined, MUL/MULC are legal ALU functions.
package b_cpu_pkg;

  localparam logic [5:0] OP_LD  = 6'h18;
  localparam logic [5:0] OP_ST  = 6'h19;
  localparam logic [5:0] OP_JMP = 6'h1B;
  localparam logic [5:0] OP_BEQ = 6'h1C;
  localparam logic [5:0] OP_BNE = 6'h1D;
  localparam logic [5:0] OP_LDR = 6'h1F;

  // op[5:4] selects the ALU class: register operand or literal operand.
  localparam logic [1:0] OP_CLASS_REG = 2'b10;
  localparam logic [1:0] OP_CLASS_LIT = 2'b11;

  localparam logic [6:0] TX_IDLE  = 7'h7F;
  localparam logic [6:0] TX_START = 7'h00;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_SUB   = 4'h1,
    ALU_MUL   = 4'h2,
    ALU_CMPEQ = 4'h4,
    ALU_CMPLT = 4'h5,
    ALU_CMPLE = 4'h6,
    ALU_AND   = 4'h8,
    ALU_OR    = 4'h9,
    ALU_XOR   = 4'hA,
    ALU_SHL   = 4'hC,
    ALU_SHR   = 4'hD,
    ALU_SRA   = 4'hE
  } alu_op_e;

  // rb lives in lit[15:11]; literal forms use the full 16 bits.
  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rc;
    logic [4:0]  ra;
    logic [15:0] lit;
  } instr_t;

  // True for ALU function codes that execute; everything else is a NOP.
  function automatic logic alu_fn_valid(input logic [3:0] fn);
    case (fn)
      ALU_ADD, ALU_SUB, ALU_CMPEQ, ALU_CMPLT, ALU_CMPLE,
      ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR, ALU_SRA: return 1'b1;
`ifdef CPU_MUL_EN
      ALU_MUL: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/b_cpu_alu.sv
// Combinational ALU for the B-processor.
// CPU_MUL_EN: when defined, a 32x32 multiplier (low word) is built.
module b_cpu_alu
  import b_cpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     alu_op,
  output logic [31:0] y
);

  // Result select; compares yield 1/0, shifts use b[4:0]
  always_comb begin
    // NOTE: default assignment first so every path drives y and no latch is inferred.
    y = '0;
    case (alu_op)
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
`ifdef CPU_MUL_EN
      // Low 32 bits are identical for signed and unsigned products.
      ALU_MUL:   y = a * b;
`endif
      ALU_CMPEQ: y = {31'd0, a == b};
      ALU_CMPLT: y = {31'd0, $signed(a) <  $signed(b)};
      ALU_CMPLE: y = {31'd0, $signed(a) <= $signed(b)};
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_XOR:   y = a ^ b;
      ALU_SHL:   y = a << b[4:0];
      ALU_SHR:   y = a >> b[4:0];
      ALU_SRA:   y = $unsigned($signed(a) >>> b[4:0]);
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/b_cpu_data.sv
// Single-cycle Beta-style processor with instruction ROM, register file,
// data RAM and a memory-mapped 7-bit transmit register driving tx.
// CPU_MUL_EN: when defined, MUL/MULC execute; otherwise they are NOPs.
// IMEM_WORDS and DMEM_WORDS are expected to be powers of two.
module b_cpu_data
  import b_cpu_pkg::*;
#(
  parameter string       PROG_FILE  = "prog.hex",
  parameter int          IMEM_WORDS = 256,
  parameter int          DMEM_WORDS = 64,
  parameter logic [31:0] TX_ADDR    = 32'hFFFC
) (
  input  logic       clk,
  input  logic       reset,
  output logic [6:0] tx
);

  localparam int          IAW        = $clog2(IMEM_WORDS);
  localparam int          DAW        = $clog2(DMEM_WORDS);
  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);
  localparam logic [31:0] PC_MASK    = IMEM_BYTES - 32'd1;

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] rf   [32];

  logic [31:0] pc;
  logic        tx_armed;

  instr_t      ins;
  logic [4:0]  rb_sel;
  logic [31:0] rd_a, rd_b, lit_sx, alu_b, alu_y;
  logic [31:0] pc_plus4, br_target, mem_addr;
  logic [31:0] ram_ld, ldr_data;
  logic        alu_en;

  assign ins      = instr_t'(imem[pc[IAW+1:2]]);
  assign lit_sx   = sext16(ins.lit);
  assign rb_sel   = (ins.op == OP_ST) ? ins.rc : ins.lit[15:11];
  assign rd_a     = (ins.ra == 5'd31) ? 32'd0 : rf[ins.ra];
  assign rd_b     = (rb_sel == 5'd31) ? 32'd0 : rf[rb_sel];
  assign alu_en   = (ins.op[5:4] == OP_CLASS_REG || ins.op[5:4] == OP_CLASS_LIT)
                    && alu_fn_valid(ins.op[3:0]);
  assign alu_b    = (ins.op[5:4] == OP_CLASS_LIT) ? lit_sx : rd_b;

  assign pc_plus4  = pc + 32'd4;
  assign br_target = pc_plus4 + (lit_sx << 2);
  assign mem_addr  = rd_a + lit_sx;
  assign ram_ld    = dmem[mem_addr[DAW+1:2]];
  // LDR sees the ROM below its size, the RAM above it.
  assign ldr_data  = (br_target < IMEM_BYTES) ? imem[br_target[IAW+1:2]]
                                              : dmem[br_target[DAW+1:2]];

  b_cpu_alu u_alu (
    .a      (rd_a),
    .b      (alu_b),
    .alu_op (alu_op_e'(ins.op[3:0])),
    .y      (alu_y)
  );

  logic [31:0] pc_next, wb_data;
  logic        wb_en, ram_we, tx_we;

  // Decode: next PC, write-back source and store destination
  always_comb begin
    pc_next = pc_plus4;
    wb_en   = 1'b0;
    wb_data = alu_y;
    ram_we  = 1'b0;
    tx_we   = 1'b0;
    if (alu_en) begin
      wb_en = 1'b1;
    end else begin
      case (ins.op)
        OP_LD: begin
          wb_en   = 1'b1;
          wb_data = ram_ld;
        end
        OP_ST: begin
          if (mem_addr == TX_ADDR) tx_we  = 1'b1;
          else                     ram_we = 1'b1;
        end
        OP_JMP: begin
          wb_en   = 1'b1;
          wb_data = pc_plus4;
          pc_next = rd_a & ~32'd3;
        end
        OP_BEQ, OP_BNE: begin
          wb_en   = 1'b1;
          wb_data = pc_plus4;
          if ((rd_a == 32'd0) == (ins.op == OP_BEQ)) pc_next = br_target;
        end
        OP_LDR: begin
          wb_en   = 1'b1;
          wb_data = ldr_data;
        end
        default: ;
      endcase
    end
  end

  // PC and transmit line: a TX store shows its value for one cycle,
  // then the line rests at START while armed, IDLE otherwise
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!reset) begin
      pc       <= '0;
      tx       <= TX_IDLE;
      tx_armed <= 1'b0;
    end else begin
      pc <= pc_next & PC_MASK;
      if (tx_we) begin
        tx       <= rd_b[6:0];
        tx_armed <= (rd_b[6:0] != TX_IDLE);
      end else begin
        tx <= tx_armed ? TX_START : TX_IDLE;
      end
    end
  end

  // Register file write port; R31 is never written
  always_ff @(posedge clk) begin
    // NOTE: storage arrays have no reset; writes are only suppressed while reset is held.
    if (reset && wb_en && ins.rc != 5'd31) rf[ins.rc] <= wb_data;
  end

  // Data RAM write port
  always_ff @(posedge clk) begin
    if (reset && ram_we) dmem[mem_addr[DAW+1:2]] <= rd_b;
  end

endmodule

// File: tb/tb_b_cpu_data.sv
// Bench for b_cpu_data: directed programs, an instruction-level model
// checked against tx and PC every cycle, plus literal register checks.
`timescale 1ns/1ps
module tb_b_cpu_data;

  localparam logic [5:0] OP_ADD   = 6'h20, OP_SUB   = 6'h21, OP_CMPLT = 6'h25;
  localparam logic [5:0] OP_CMPLE = 6'h26, OP_OR    = 6'h29, OP_SHR   = 6'h2D;
  localparam logic [5:0] OP_ADDC  = 6'h30, OP_SUBC  = 6'h31, OP_MULC  = 6'h32;
  localparam logic [5:0] OP_CMPEQC= 6'h34, OP_ANDC  = 6'h38, OP_XORC  = 6'h3A;
  localparam logic [5:0] OP_SHLC  = 6'h3C, OP_SRAC  = 6'h3E;
  localparam logic [5:0] OP_LD    = 6'h18, OP_ST    = 6'h19, OP_JMP   = 6'h1B;
  localparam logic [5:0] OP_BEQ   = 6'h1C, OP_BNE   = 6'h1D, OP_LDR   = 6'h1F;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] tx;

  always #5 clk = ~clk;

  b_cpu_data #(.PROG_FILE("")) dut (
    .clk   (clk),
    .reset (reset),
    .tx    (tx)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- program construction ----------------
  logic [31:0] img  [256];
  logic [31:0] prog [256];

  function automatic logic [31:0] op_r(input logic [5:0] op, input int rc, input int ra, input int rb);
    return {op, 5'(rc), 5'(ra), 5'(rb), 11'd0};
  endfunction

  function automatic logic [31:0] op_l(input logic [5:0] op, input int rc, input int ra, input int lit);
    return {op, 5'(rc), 5'(ra), 16'(lit)};
  endfunction

  function automatic logic [31:0] halt();
    return op_l(OP_BEQ, 31, 31, -1);
  endfunction

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 32'd0;
  endtask

  // Program R10 = 0xFFFC (transmit register address) at words 0..1.
  task automatic tx_base();
    img[0] = op_l(OP_ADDC, 10, 31, 'h3FFF);
    img[1] = op_l(OP_SHLC, 10, 10, 2);
  endtask

  // ---------------- instruction-level model ----------------
  logic [31:0] m_rf  [32];
  logic [31:0] m_ram [64];
  logic [31:0] m_pc;
  logic [6:0]  m_tx;
  logic        m_armed;
  logic        m_valid = 1'b0;
  logic [31:0] m_wr    = '0;
  logic [6:0]  cap [$];

  function automatic logic [31:0] m_rd(input int r);
    return (r == 31) ? 32'd0 : m_rf[r];
  endfunction

  task automatic model_step();
    logic [31:0] ins, a, b, lit, res, npc, addr;
    logic [5:0]  op;
    int          rc, ra, rb;
    logic        wr, tx_st;
    logic [6:0]  tx_val;
    ins = prog[m_pc[9:2]];
    op  = ins[31:26];
    rc  = int'(ins[25:21]);
    ra  = int'(ins[20:16]);
    rb  = int'(ins[15:11]);
    lit = {{16{ins[15]}}, ins[15:0]};
    a   = m_rd(ra);
    npc = m_pc + 4;
    res = 0; wr = 0; tx_st = 0; tx_val = 0;
    if (op[5] == 1'b1) begin
      b  = op[4] ? lit : m_rd(rb);
      wr = 1;
      case (op[3:0])
        4'h0: res = a + b;
        4'h1: res = a - b;
        4'h2: begin
`ifdef CPU_MUL_EN
          res = a * b;
`else
          wr = 0;
`endif
        end
        4'h4: res = (a == b) ? 1 : 0;
        4'h5: res = ($signed(a) <  $signed(b)) ? 1 : 0;
        4'h6: res = ($signed(a) <= $signed(b)) ? 1 : 0;
        4'h8: res = a & b;
        4'h9: res = a | b;
        4'hA: res = a ^ b;
        4'hC: res = a << b[4:0];
        4'hD: res = a >> b[4:0];
        4'hE: res = $unsigned($signed(a) >>> b[4:0]);
        default: wr = 0;
      endcase
    end else begin
      case (op)
        OP_LD: begin addr = a + lit; res = m_ram[addr[7:2]]; wr = 1; end
        OP_ST: begin
          addr = a + lit;
          if (addr == 32'hFFFC) begin tx_st = 1; tx_val = m_rd(rc) & 7'h7F; end
          else m_ram[addr[7:2]] = m_rd(rc);
        end
        OP_JMP: begin res = m_pc + 4; wr = 1; npc = a & ~32'd3; end
        OP_BEQ: begin res = m_pc + 4; wr = 1; if (a == 0) npc = m_pc + 4 + 4 * lit; end
        OP_BNE: begin res = m_pc + 4; wr = 1; if (a != 0) npc = m_pc + 4 + 4 * lit; end
        OP_LDR: begin
          addr = m_pc + 4 + 4 * lit;
          res  = (addr < 1024) ? prog[addr[9:2]] : m_ram[addr[7:2]];
          wr   = 1;
        end
        default: ;
      endcase
    end
    if (wr && rc != 31) begin m_rf[rc] = res; m_wr[rc] = 1'b1; end
    if (tx_st) begin m_tx = tx_val; m_armed = (tx_val != 7'h7F); end
    else m_tx = m_armed ? 7'h00 : 7'h7F;
    m_pc = npc % 1024;
  endtask

  // Compare process: check the DUT against the model, then advance the model
  always @(negedge clk) begin
    if (m_valid) begin
      check("tx", {25'd0, tx}, {25'd0, m_tx});
      check("pc", dut.pc, m_pc);
      cap.push_back(tx);
    end
    if (!reset) begin
      m_pc = 0; m_tx = 7'h7F; m_armed = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      model_step();
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic go();
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      prog[i] = img[i];
      dut.imem[i] = img[i];
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_regs(input string tag);
    for (int r = 0; r < 31; r++)
      if (m_wr[r]) check($sformatf("%s_R%0d", tag, r), dut.rf[r], m_rf[r]);
  endtask

  task automatic check_stream(input string name, input int start,
                              input logic [31:0] exp_chars, input int exp_n);
    logic [31:0] acc   = 0;
    int          n     = 0;
    logic [6:0]  first = 7'h7F;
    bit          seen  = 0;
    for (int i = start; i < cap.size(); i++) begin
      if (!seen && cap[i] != 7'h7F) begin first = cap[i]; seen = 1; end
      if (cap[i] != 7'h00 && cap[i] != 7'h7F) begin
        acc = {acc[23:0], 1'b0, cap[i]};
        n++;
      end
    end
    check({name, "_start"}, {25'd0, first}, 32'h00);
    check({name, "_text"},  acc, exp_chars);
    check({name, "_count"}, n, exp_n);
    check({name, "_end"},   {25'd0, cap[cap.size()-1]}, 32'h7F);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int  st;
    bit  found;

    // 1: all-NOP ROM, tx idle, PC advances by 4 per cycle
    clear_img();
    go();
    run(5);
    check("nop_pc", dut.pc, 32'd20);
    check("nop_tx", {25'd0, tx}, 32'h7F);
    run(5);

    // 2: print "Hi"
    clear_img();
    tx_base();
    img[2] = op_l(OP_ST, 31, 10, 0);
    img[3] = op_l(OP_ADDC, 1, 31, 'h48);
    img[4] = op_l(OP_ST, 1, 10, 0);
    img[5] = op_l(OP_ADDC, 1, 31, 'h69);
    img[6] = op_l(OP_ST, 1, 10, 0);
    img[7] = op_l(OP_ADDC, 1, 31, 'h7F);
    img[8] = op_l(OP_ST, 1, 10, 0);
    img[9] = halt();
    go();
    st = cap.size();
    run(20);
    check_stream("hi", st, 32'h4869, 2);
    check("hi_R10", dut.rf[10], 32'h0000FFFC);

    // 3: ALU operations
    clear_img();
    img[0]  = op_l(OP_ADDC, 1, 31, 5);
    img[1]  = op_l(OP_ADDC, 2, 31, -3);
    img[2]  = op_r(OP_ADD, 3, 1, 2);
    img[3]  = op_r(OP_CMPLT, 4, 2, 1);
    img[4]  = op_l(OP_SRAC, 5, 2, 1);
    img[5]  = op_r(OP_SUB, 6, 1, 2);
    img[6]  = op_l(OP_CMPEQC, 7, 1, 5);
    img[7]  = op_r(OP_CMPLE, 8, 1, 2);
    img[8]  = op_l(OP_ANDC, 9, 2, 'hFF);
    img[9]  = op_r(OP_OR, 11, 1, 2);
    img[10] = op_l(OP_XORC, 12, 1, 'hFFFF);
    img[11] = op_l(OP_SHLC, 13, 1, 4);
    img[12] = op_r(OP_SHR, 14, 2, 1);
    img[13] = op_l(OP_ADDC, 15, 31, 'h11);
    img[14] = op_l(6'h23, 15, 1, 1);
    img[15] = halt();
    go();
    run(25);
    check("alu_R3", dut.rf[3], 32'd2);
    check("alu_R4", dut.rf[4], 32'd1);
    check("alu_R5", dut.rf[5], 32'hFFFFFFFE);
    check("alu_R6", dut.rf[6], 32'd8);
    check("alu_R7", dut.rf[7], 32'd1);
    check("alu_R8", dut.rf[8], 32'd0);
    check("alu_R9", dut.rf[9], 32'hFD);
    check("alu_R11", dut.rf[11], 32'hFFFFFFFD);
    check("alu_R12", dut.rf[12], 32'hFFFFFFFA);
    check("alu_R13", dut.rf[13], 32'h50);
    check("alu_R14", dut.rf[14], 32'h07FFFFFF);
    check("alu_R15", dut.rf[15], 32'h11);
    check("model_R3", m_rf[3], 32'd2);
    check("model_R5", m_rf[5], 32'hFFFFFFFE);
    check_regs("alu");

    // 4: countdown loop printing "321"
    clear_img();
    tx_base();
    img[2]  = op_l(OP_ST, 31, 10, 0);
    img[3]  = op_l(OP_ADDC, 1, 31, 3);
    img[4]  = op_l(OP_ADDC, 2, 1, 'h30);
    img[5]  = op_l(OP_ST, 2, 10, 0);
    img[6]  = op_l(OP_SUBC, 1, 1, 1);
    img[7]  = op_l(OP_BNE, 7, 1, -4);
    img[8]  = op_l(OP_ADDC, 3, 31, 'h7F);
    img[9]  = op_l(OP_ST, 3, 10, 0);
    img[10] = halt();
    go();
    st = cap.size();
    run(40);
    check_stream("loop", st, 32'h333231, 3);
    check("loop_R7", dut.rf[7], 32'd32);
    check("loop_R1", dut.rf[1], 32'd0);
    check_regs("loop");

    // 5: memory, R31, LDR from ROM, RAM wrap, JMP
    clear_img();
    img[0]  = op_l(OP_ADDC, 1, 31, 'h1234);
    img[1]  = op_l(OP_ADDC, 7, 31, 9);
    img[2]  = op_l(OP_ST, 1, 31, 8);
    img[3]  = op_l(OP_LD, 6, 31, 8);
    img[4]  = op_l(OP_ADDC, 31, 31, 77);
    img[5]  = op_r(OP_ADD, 7, 31, 31);
    img[6]  = op_l(OP_LDR, 8, 31, -7);
    img[7]  = op_l(OP_ADDC, 2, 31, 'h55);
    img[8]  = op_l(OP_ST, 2, 31, 264);
    img[9]  = op_l(OP_LD, 9, 31, 8);
    img[10] = op_l(OP_ADDC, 12, 31, 59);
    img[11] = op_l(OP_JMP, 11, 12, 0);
    img[12] = op_l(OP_ADDC, 13, 31, 1);
    img[13] = op_l(OP_ADDC, 13, 31, 2);
    img[14] = halt();
    go();
    run(25);
    check("mem_R6", dut.rf[6], 32'h1234);
    check("mem_R7_r31", dut.rf[7], 32'd0);
    check("mem_R8_ldr", dut.rf[8], op_l(OP_ADDC, 1, 31, 'h1234));
    check("mem_R9_wrap", dut.rf[9], 32'h55);
    check("mem_R11_link", dut.rf[11], 32'd48);
    check("mem_pc", dut.pc, 32'd56);
    check_regs("mem");

    // 6: reset mid-string, then replay; MULC
    clear_img();
    tx_base();
    img[2] = op_l(OP_ST, 31, 10, 0);
    img[3] = op_l(OP_ADDC, 1, 31, 'h48);
    img[4] = op_l(OP_ST, 1, 10, 0);
    img[5] = op_l(OP_ADDC, 1, 31, 'h69);
    img[6] = op_l(OP_ST, 1, 10, 0);
    img[7] = op_l(OP_ADDC, 1, 31, 'h7F);
    img[8] = op_l(OP_ST, 1, 10, 0);
    img[9] = halt();
    go();
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (tx == 7'h48) found = 1;
    end
    check("rst_wait_H", {31'd0, found}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_tx", {25'd0, tx}, 32'h7F);
    check("rst_pc", dut.pc, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    st = cap.size();
    run(20);
    check_stream("replay", st, 32'h4869, 2);

    clear_img();
    img[0] = op_l(OP_ADDC, 1, 31, 7);
    img[1] = op_l(OP_MULC, 1, 1, -6);
    img[2] = halt();
    go();
    run(6);
`ifdef CPU_MUL_EN
    check("mul_R1", dut.rf[1], 32'hFFFFFFD6);
`else
    check("mul_R1", dut.rf[1], 32'd7);
`endif
    check_regs("mul");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
